pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage MIPS pipeline. Drives the enable and flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB pipe registers and the PC enable, from cache hits, load-use hazards, control-flow redirects and halt. Holds a small state machine for data-memory waits and the terminal halt condition. Sits beside the datapath in the top-level CPU, with a Mealy output path.

---
 rtl/pipeline_ctrl_if.sv | 46 ++++
 rtl/pipeline_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and pipe-register controls between datapath and pipeline_ctrl
interface pipeline_ctrl_if;
  logic        ihit;
  logic        dhit;
  logic        mem_dREN;
  logic        mem_dWEN;
  logic        ex_dREN;
  logic [4:0]  ex_wsel;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_branch_taken;
  logic        id_jump;
  logic        wb_halt;

  logic        pc_EN;
  logic        ifid_EN;
  logic        idex_EN;
  logic        exmem_EN;
  logic        memwb_EN;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        halt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // master: the sequencer
  modport master (
    input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
           id_uses_rt, ex_branch_taken, id_jump, wb_halt,
    output pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, stall_cnt, flush_cnt
  );

  // slave: the datapath
  modport slave (
    output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel, id_rs, id_rt,
           id_uses_rt, ex_branch_taken, id_jump, wb_halt,
    input  pc_EN, ifid_EN, idex_EN, exmem_EN, memwb_EN,
           ifid_flush, idex_flush, exmem_flush, memwb_flush,
           halt, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the five-stage pipeline
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module pipeline_ctrl (
  input  logic            CLK,
  input  logic            RST,
  pipeline_ctrl_if.master pif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   halt_q, halt_d;

  logic dmem_pend;
  logic load_use;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_fl, idex_fl, exmem_fl, memwb_fl;

  always_comb begin
    dmem_pend = (pif.mem_dREN | pif.mem_dWEN) & ~pif.dhit;
    load_use  = pif.ex_dREN & (pif.ex_wsel != 5'd0) &
                ((pif.ex_wsel == pif.id_rs) |
                 (pif.id_uses_rt & (pif.ex_wsel == pif.id_rt)));
  end

  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    idex_en  = 1'b1;
    exmem_en = 1'b1;
    memwb_en = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    memwb_fl = 1'b0;
    state_d  = state_q;

    if (RST) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      exmem_fl = 1'b1;
      memwb_fl = 1'b1;
      state_d  = RUN;
    end else begin
      case (state_q)
        HALT: begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end
        default: begin
          if (pif.wb_halt) begin
            // freeze everything; the halting instruction has already retired
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = HALT;
          end else if (dmem_pend) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_fl = 1'b1;
            state_d  = DSTALL;
          end else begin
            state_d = RUN;
            if (pif.ex_branch_taken) begin
              ifid_fl = 1'b1;
              idex_fl = 1'b1;
            end else if (load_use) begin
              pc_en   = 1'b0;
              ifid_en = 1'b0;
              idex_fl = 1'b1;
            end else if (pif.id_jump) begin
              ifid_fl = 1'b1;
            end else if (!pif.ihit) begin
              pc_en   = 1'b0;
              ifid_fl = 1'b1;
            end
          end
        end
      endcase
    end

    halt_d = (state_d == HALT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!RST && (state_q != HALT)) begin
      if (!pc_en)
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (ifid_fl | idex_fl)
        flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pif.stall_cnt = stall_cnt_q;
  assign pif.flush_cnt = flush_cnt_q;
`else
  assign pif.stall_cnt = 32'd0;
  assign pif.flush_cnt = 32'd0;
`endif

  assign pif.pc_EN       = pc_en;
  assign pif.ifid_EN     = ifid_en;
  assign pif.idex_EN     = idex_en;
  assign pif.exmem_EN    = exmem_en;
  assign pif.memwb_EN    = memwb_en;
  assign pif.ifid_flush  = ifid_fl;
  assign pif.idex_flush  = idex_fl;
  assign pif.exmem_flush = exmem_fl;
  assign pif.memwb_flush = memwb_fl;
  assign pif.halt        = halt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  pipeline_ctrl_if pif();

  pipeline_ctrl u_dut (
    .CLK (clk),
    .RST (rst),
    .pif (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
  localparam logic [8:0] V_RST    = 9'b0_0000_1111;
  localparam logic [8:0] V_RUN    = 9'b1_1111_0000;
  localparam logic [8:0] V_LDUSE  = 9'b0_0111_0100;
  localparam logic [8:0] V_DPEND  = 9'b0_0001_0001;
  localparam logic [8:0] V_BRANCH = 9'b1_1111_1100;
  localparam logic [8:0] V_JUMP   = 9'b1_1111_1000;
  localparam logic [8:0] V_MISS   = 9'b0_1111_1000;
  localparam logic [8:0] V_FROZEN = 9'b0_0000_0000;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  function automatic logic [8:0] ctl();
    return {pif.pc_EN, pif.ifid_EN, pif.idex_EN, pif.exmem_EN, pif.memwb_EN,
            pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush};
  endfunction

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
    return PERF ? v : 32'd0;
  endfunction

  task automatic set_idle();
    pif.ihit            = 1'b1;
    pif.dhit            = 1'b0;
    pif.mem_dREN        = 1'b0;
    pif.mem_dWEN        = 1'b0;
    pif.ex_dREN         = 1'b0;
    pif.ex_wsel         = 5'd0;
    pif.id_rs           = 5'd0;
    pif.id_rt           = 5'd0;
    pif.id_uses_rt      = 1'b0;
    pif.ex_branch_taken = 1'b0;
    pif.id_jump         = 1'b0;
    pif.wb_halt         = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    #1;
    checks++;
    if (ctl() !== V_RST) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl(), V_RST); end
    @(negedge clk); #1;
    checks++;
    if (ctl() !== V_RST) begin errors++; $display("FAIL reset_ctl2 got=%b exp=%b", ctl(), V_RST); end
    checks++;
    if (pif.halt !== 1'b0) begin errors++; $display("FAIL reset_halt got=%b exp=0", pif.halt); end
    checks++;
    if (pif.stall_cnt !== 32'd0 || pif.flush_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pif.stall_cnt, pif.flush_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL reset_release got=%b exp=%b", ctl(), V_RUN); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_idle();
    pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd5; pif.id_rs = 5'd5;
    #1;
    checks++;
    if (ctl() !== V_LDUSE) begin errors++; $display("FAIL ldu_rs got=%b exp=%b", ctl(), V_LDUSE); end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL ldu_clear got=%b exp=%b", ctl(), V_RUN); end
    @(negedge clk);
    pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd0; pif.id_rs = 5'd0;
    #1;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL ldu_r0 got=%b exp=%b", ctl(), V_RUN); end
    @(negedge clk);
    pif.ex_wsel = 5'd7; pif.id_rs = 5'd3; pif.id_rt = 5'd7; pif.id_uses_rt = 1'b1;
    #1;
    checks++;
    if (ctl() !== V_LDUSE) begin errors++; $display("FAIL ldu_rt got=%b exp=%b", ctl(), V_LDUSE); end
    @(negedge clk);
    pif.id_uses_rt = 1'b0;
    #1;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL ldu_rt_unused got=%b exp=%b", ctl(), V_RUN); end
  endtask

  task automatic test_dmem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pif.mem_dREN = 1'b1; pif.dhit = 1'b0;
      #1;
      checks++;
      if (ctl() !== V_DPEND) begin errors++; $display("FAIL dmem_wait%0d got=%b exp=%b", i, ctl(), V_DPEND); end
      @(negedge clk);
    end
    pif.dhit = 1'b1;
    #1;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL dmem_done got=%b exp=%b", ctl(), V_RUN); end
    @(negedge clk);
    set_idle();
    pif.mem_dWEN = 1'b1; pif.dhit = 1'b1;
    #1;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL dmem_first_hit got=%b exp=%b", ctl(), V_RUN); end
    checks++;
    if (pif.stall_cnt !== cnt_exp(32'd3)) begin
      errors++; $display("FAIL dmem_stall_cnt got=%0d exp=%0d", pif.stall_cnt, cnt_exp(32'd3));
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    set_idle();
    pif.ex_branch_taken = 1'b1; pif.ihit = 1'b0;
    pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd9; pif.id_rs = 5'd9;
    #1;
    checks++;
    if (ctl() !== V_BRANCH) begin errors++; $display("FAIL branch_over_ldu got=%b exp=%b", ctl(), V_BRANCH); end
    @(negedge clk);
    pif.mem_dREN = 1'b1; pif.dhit = 1'b0;
    #1;
    checks++;
    if (ctl() !== V_DPEND) begin errors++; $display("FAIL dmem_over_branch got=%b exp=%b", ctl(), V_DPEND); end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (ctl() !== V_RUN) begin errors++; $display("FAIL branch_after got=%b exp=%b", ctl(), V_RUN); end
  endtask

  task automatic test_jump_miss();
    @(negedge clk);
    set_idle();
    pif.id_jump = 1'b1;
    #1;
    checks++;
    if (ctl() !== V_JUMP) begin errors++; $display("FAIL jump got=%b exp=%b", ctl(), V_JUMP); end
    @(negedge clk);
    pif.id_jump = 1'b0; pif.ihit = 1'b0;
    #1;
    checks++;
    if (ctl() !== V_MISS) begin errors++; $display("FAIL imiss got=%b exp=%b", ctl(), V_MISS); end
  endtask

  task automatic test_perf_cnt();
    do_reset();
    pif.ex_branch_taken = 1'b1;
    @(negedge clk);
    set_idle();
    pif.id_jump = 1'b1;
    @(negedge clk);
    set_idle();
    pif.ihit = 1'b0;
    @(negedge clk);
    set_idle();
    pif.ex_dREN = 1'b1; pif.ex_wsel = 5'd4; pif.id_rs = 5'd4;
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (pif.flush_cnt !== cnt_exp(32'd4)) begin
      errors++; $display("FAIL flush_cnt got=%0d exp=%0d", pif.flush_cnt, cnt_exp(32'd4));
    end
    checks++;
    if (pif.stall_cnt !== cnt_exp(32'd2)) begin
      errors++; $display("FAIL stall_cnt got=%0d exp=%0d", pif.stall_cnt, cnt_exp(32'd2));
    end
  endtask

  task automatic test_halt();
    do_reset();
    pif.mem_dREN = 1'b1; pif.dhit = 1'b0; pif.wb_halt = 1'b1;
    #1;
    checks++;
    if (pif.halt !== 1'b0) begin errors++; $display("FAIL halt_early got=%b exp=0", pif.halt); end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if (pif.halt !== 1'b1) begin errors++; $display("FAIL halt_set got=%b exp=1", pif.halt); end
    checks++;
    if (ctl() !== V_FROZEN) begin errors++; $display("FAIL halt_ctl got=%b exp=%b", ctl(), V_FROZEN); end
    repeat (3) @(negedge clk);
    pif.ihit = 1'b0;
    pif.ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (pif.halt !== 1'b1 || ctl() !== V_FROZEN) begin
      errors++; $display("FAIL halt_hold got=%b/%b exp=1/%b", pif.halt, ctl(), V_FROZEN);
    end
    @(negedge clk); #1;
    checks++;
    if (pif.stall_cnt !== cnt_exp(32'd1) || pif.flush_cnt !== 32'd0) begin
      errors++; $display("FAIL halt_cnt_frozen got=%0d/%0d exp=%0d/0", pif.stall_cnt, pif.flush_cnt, cnt_exp(32'd1));
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ctl() !== V_RST) begin errors++; $display("FAIL halt_rst_ctl got=%b exp=%b", ctl(), V_RST); end
    @(negedge clk);
    rst = 1'b0;
    set_idle();
    #1;
    checks++;
    if (pif.halt !== 1'b0 || ctl() !== V_RUN) begin
      errors++; $display("FAIL halt_exit got=%b/%b exp=0/%b", pif.halt, ctl(), V_RUN);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_branch();
    test_jump_miss();
    test_perf_cnt();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
